// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with shared clock, parallel load and
// selectable JK / D / T / up-down counter behaviour.
module jk_reg_bank #(
    parameter int          WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic             up,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LP_RESET = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LP_ONE   = WIDTH'(1);
    localparam logic [1:0]       MODE_JK  = 2'b00;
    localparam logic [1:0]       MODE_D   = 2'b01;
    localparam logic [1:0]       MODE_T   = 2'b10;
    localparam logic [1:0]       MODE_CNT = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;

    // Next-state selection for the enabled, non-load case
    always_comb begin
        w_next = r_q;
        case (mode)
            MODE_JK:  w_next = (j & ~r_q) | (~k & r_q);
            MODE_D:   w_next = j;
            MODE_T:   w_next = r_q ^ j;
            MODE_CNT: begin
                if (up) begin
                    w_next = r_q + LP_ONE;
                end else begin
                    w_next = r_q - LP_ONE;
                end
            end
            default:  w_next = r_q;
        endcase
    end

    // Terminal count flags the edge that will wrap the counter; load suppresses it
    always_comb begin
        w_tc = 1'b0;
        if ((mode == MODE_CNT) && en && !load) begin
            if (up) begin
                w_tc = &r_q;
            end else begin
                w_tc = ~|r_q;
            end
        end else begin
            w_tc = 1'b0;
        end
    end

    // State register: reset, then load, then enable-gated mode update
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= LP_RESET;
        end else if (load) begin
            r_q <= j;
        end else if (en) begin
            r_q <= w_next;
        end else begin
            r_q <= r_q;
        end
    end

    assign q  = r_q;
    assign qn = ~r_q;
    assign tc = w_tc;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: a 4-bit instance and a 1-bit instance
// with RESET_VALUE=1, driven by a directed vector table.
module tb_jk_reg_bank;

    typedef struct {
        int         id;
        bit         sel;      // 0 = 4-bit DUT, 1 = 1-bit DUT
        logic       reset;
        logic       en;
        logic       load;
        logic [1:0] mode;
        logic       up;
        logic [3:0] j;
        logic [3:0] k;
        logic       exp_tc;   // tc before the edge
        logic [3:0] exp_q;    // q after the edge
    } vec_t;

    typedef struct {
        int         id;
        bit         sel;
        logic       exp_tc;
        logic [3:0] exp_q;
        logic [3:0] exp_qn;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset4, en4, load4, up4, reset1, en1, load1, up1;
    logic [1:0] mode4, mode1;
    logic [3:0] j4, k4, q4, qn4;
    logic [0:0] j1, k1, q1, qn1;
    logic       tc4, tc1;
    logic       tc4_pre, tc1_pre;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    jk_reg_bank #(.WIDTH(4), .RESET_VALUE(32'd0)) dut4 (
        .clock(clock), .reset(reset4), .en(en4), .load(load4), .mode(mode4),
        .up(up4), .j(j4), .k(k4), .q(q4), .qn(qn4), .tc(tc4)
    );

    jk_reg_bank #(.WIDTH(1), .RESET_VALUE(32'd1)) dut1 (
        .clock(clock), .reset(reset1), .en(en1), .load(load1), .mode(mode1),
        .up(up1), .j(j1), .k(k1), .q(q1), .qn(qn1), .tc(tc1)
    );

    task automatic add(input bit sel, input logic rst, input logic en, input logic ld,
                       input logic [1:0] md, input logic u, input logic [3:0] jj,
                       input logic [3:0] kk, input logic etc, input logic [3:0] eq);
        vec_t v;
        v.id = vecs.size(); v.sel = sel; v.reset = rst; v.en = en; v.load = ld;
        v.mode = md; v.up = u; v.j = jj; v.k = kk; v.exp_tc = etc; v.exp_q = eq;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int id, input logic [3:0] got,
                         input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL step%0d %s: got %b want %b", id, name, got, want);
        end
    endtask

    // Monitor: sample tc mid-cycle, then compare q/qn just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            tc4_pre = tc4;
            tc1_pre = tc1;
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel == 1'b0) begin
                    check("tc", e.id, {3'b000, tc4_pre}, {3'b000, e.exp_tc});
                    check("q",  e.id, q4,  e.exp_q);
                    check("qn", e.id, qn4, e.exp_qn);
                end else begin
                    check("tc", e.id, {3'b000, tc1_pre}, {3'b000, e.exp_tc});
                    check("q",  e.id, {3'b000, q1},  e.exp_q);
                    check("qn", e.id, {3'b000, qn1}, e.exp_qn);
                end
            end
        end
    end

    // Driver: apply one vector per negative edge and queue its expectation
    initial begin
        exp_t e;
        reset4 = 1'b0; en4 = 1'b0; load4 = 1'b0; mode4 = 2'b00; up4 = 1'b0;
        j4 = 4'b0000; k4 = 4'b0000;
        reset1 = 1'b1; en1 = 1'b0; load1 = 1'b0; mode1 = 2'b00; up1 = 1'b0;
        j1 = 1'b0; k1 = 1'b0;

        //   sel  rst   en    load  mode   up    j        k        tc    q
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b1010, 4'b0000, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0011, 4'b0011, 1'b0, 4'b1001);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0001);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'b0110, 4'b1111, 1'b0, 4'b0110);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0011);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0110);
        add(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 4'b1110, 4'b0000, 1'b0, 4'b1110);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'b1111);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1111);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1110);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        add(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0101);
        add(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 4'b1010, 4'b0000, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1111);
        add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001);
        add(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        add(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0001);
        add(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);

        foreach (vecs[i]) begin
            @(negedge clock);
            if (vecs[i].sel == 1'b0) begin
                reset4 = vecs[i].reset; en4 = vecs[i].en; load4 = vecs[i].load;
                mode4 = vecs[i].mode; up4 = vecs[i].up; j4 = vecs[i].j; k4 = vecs[i].k;
                reset1 = 1'b1; en1 = 1'b0; load1 = 1'b0; mode1 = 2'b00;
            end else begin
                reset1 = vecs[i].reset; en1 = vecs[i].en; load1 = vecs[i].load;
                mode1 = vecs[i].mode; up1 = vecs[i].up; j1 = vecs[i].j[0:0]; k1 = vecs[i].k[0:0];
                reset4 = 1'b0; en4 = 1'b0; load4 = 1'b0; mode4 = 2'b00;
            end
            e.id     = vecs[i].id;
            e.sel    = vecs[i].sel;
            e.exp_tc = vecs[i].exp_tc;
            e.exp_q  = vecs[i].exp_q;
            e.exp_qn = vecs[i].sel ? {3'b000, ~vecs[i].exp_q[0]} : ~vecs[i].exp_q;
            sb.push_back(e);
        end

        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
